ws_frame_sequencer: RTL and testbench

- Sequences one full refresh of the 4x4 WS2812 binary-clock matrix.
- Snapshots the four BCD time digits (h1, h0, m1, m0) and maps each digit bit to a pixel.
- Streams 16 GRB pixel words over a valid/ready handshake to the WS2812 bit serializer, then enforces the latch (reset) low gap.
- Sits in top between the timekeeping counter and the serializer that drives ws_data.

---
 rtl/ws_pkg.sv | 22 ++
 rtl/ws_pixel_map.sv | 39 +++
 rtl/ws_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_ws_frame_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared types and constants for the WS2812 binary-clock frame sequencer.
package ws_pkg;

    localparam int unsigned WS_NUM_COLS = 4;
    localparam int unsigned WS_NUM_ROWS = 4;
    localparam int unsigned WS_NUM_PIX  = WS_NUM_COLS * WS_NUM_ROWS;

    // Pixel word in WS2812 wire order: green, red, blue.
    typedef logic [23:0] grb_t;

    localparam grb_t WS_ON_COLOUR  = 24'h00_40_00;
    localparam grb_t WS_OFF_COLOUR = 24'h00_00_04;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StDrain,
        StLatch
    } ws_state_e;

endpackage

// File: rtl/ws_pixel_map.sv
// Combinational pixel lookup: strip index + digit snapshot -> GRB word.
// Column 0 is the most significant digit; row 0 is the digit LSB. With
// SERPENTINE set, odd columns run in the opposite direction along the strip.
// NUM_COLS and NUM_ROWS must be powers of two so the index splits into fields.
module ws_pixel_map
    import ws_pkg::*;
#(
    parameter int unsigned NUM_COLS   = WS_NUM_COLS,
    parameter int unsigned NUM_ROWS   = WS_NUM_ROWS,
    parameter grb_t        ON_COLOUR  = WS_ON_COLOUR,
    parameter grb_t        OFF_COLOUR = WS_OFF_COLOUR,
    parameter bit          SERPENTINE = 1'b1
) (
    input  logic [$clog2(NUM_COLS*NUM_ROWS)-1:0] idx_i,
    input  logic [NUM_COLS*NUM_ROWS-1:0]         snap_i,
    output logic [23:0]                          pix_data_o
);

    localparam int unsigned IdxW = $clog2(NUM_COLS * NUM_ROWS);
    localparam int unsigned RowW = $clog2(NUM_ROWS);
    localparam int unsigned ColW = $clog2(NUM_COLS);

    logic [ColW-1:0] col;
    logic [RowW-1:0] row;
    logic [RowW-1:0] row_eff;
    logic [IdxW-1:0] bit_idx;

    // Split the index, fold the serpentine direction and pick the snapshot bit.
    always_comb begin
        col     = idx_i[IdxW-1:RowW];
        row     = idx_i[RowW-1:0];
        // ~row == NUM_ROWS-1-row for a power-of-two row count.
        row_eff = (SERPENTINE && col[0]) ? ~row : row;
        // Column 0 lives in the top digit field, hence the inverted column.
        bit_idx = {~col, row_eff};
        pix_data_o = snap_i[bit_idx] ? ON_COLOUR : OFF_COLOUR;
    end

endmodule

// File: rtl/ws_frame_sequencer.sv
// Sequences one refresh of the 4x4 WS2812 binary-clock matrix: snapshots the
// digits, streams one GRB word per pixel over valid/ready, waits for the
// serializer to drain, then holds the latch gap before reporting frame_done.
module ws_frame_sequencer
    import ws_pkg::*;
#(
    parameter int unsigned NUM_COLS     = WS_NUM_COLS,
    parameter int unsigned NUM_ROWS     = WS_NUM_ROWS,
    parameter grb_t        ON_COLOUR    = WS_ON_COLOUR,
    parameter grb_t        OFF_COLOUR   = WS_OFF_COLOUR,
    parameter bit          SERPENTINE   = 1'b1,
    parameter int unsigned LATCH_CYCLES = 600
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_req,
    input  logic [NUM_COLS*NUM_ROWS-1:0] digits,
    output logic [23:0]                  pix_data,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    input  logic                         tx_idle,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned NumPix = NUM_COLS * NUM_ROWS;
    localparam int unsigned IdxW   = $clog2(NumPix);
    localparam int unsigned CntW   = $clog2(LATCH_CYCLES + 1);

    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumPix - 1);
    localparam logic [CntW-1:0] LatchLoad = CntW'(LATCH_CYCLES - 1);

    ws_state_e             state_q, state_d;
    logic [NumPix-1:0]     snap_q, snap_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [23:0]           pix_data_q, pix_data_d;
    logic                  pix_valid_q, pix_valid_d;

    logic                  start;
    logic                  xfer;
    logic                  last;
    logic [IdxW-1:0]       map_idx;
    logic [23:0]           map_word;

    assign start = (state_q == StIdle) && (frame_req || pend_q);
    assign xfer  = pix_valid_q && pix_ready;
    assign last  = (idx_q == LastIdx);

    // In SEND the lookup runs one pixel ahead so the next word is ready on
    // the cycle after a transfer; in LOAD it fetches the current pixel.
    assign map_idx = (state_q == StSend) ? idx_q + 1'b1 : idx_q;

    ws_pixel_map #(
        .NUM_COLS   (NUM_COLS),
        .NUM_ROWS   (NUM_ROWS),
        .ON_COLOUR  (ON_COLOUR),
        .OFF_COLOUR (OFF_COLOUR),
        .SERPENTINE (SERPENTINE)
    ) u_pixel_map (
        .idx_i      (map_idx),
        .snap_i     (snap_q),
        .pix_data_o (map_word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend:  if (xfer && last) state_d = StDrain;
            StDrain: if (tx_idle) state_d = StLatch;
            StLatch: if (cnt_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers: snapshot, index, latch counter, pending flag, pixel port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    // Datapath next-state: requests outside IDLE collapse into one pending frame.
    always_comb begin
        snap_d      = snap_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q | frame_req;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d = digits;
                    idx_d  = '0;
                    pend_d = 1'b0;
                end
            end
            StLoad: begin
                pix_data_d  = map_word;
                pix_valid_d = 1'b1;
            end
            StSend: begin
                if (xfer) begin
                    if (last) begin
                        pix_valid_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        pix_data_d = map_word;
                    end
                end
            end
            StDrain: begin
                if (tx_idle) cnt_d = LatchLoad;
            end
            StLatch: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StLatch) && (cnt_q == '0);
        pix_data   = pix_data_q;
        pix_valid  = pix_valid_q;
    end

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Self-checking bench for ws_frame_sequencer against a digit-level model.
module tb_ws_frame_sequencer;

    localparam int          LATCH = 600;
    localparam logic [23:0] ON_C  = 24'h00_40_00;
    localparam logic [23:0] OFF_C = 24'h00_00_04;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_req = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        pix_ready = 1'b0;
    logic        tx_idle = 1'b1;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ws_frame_sequencer #(
        .LATCH_CYCLES (LATCH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_req  (frame_req),
        .digits     (digits),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .tx_idle    (tx_idle),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Model: pixel p shows bit r of the digit in column p/4 (column 0 = h1),
    // with odd columns traversed from the top bit down.
    function automatic logic [23:0] exp_word(input logic [15:0] s, input int p);
        int col;
        int row;
        int r;
        int digit;
        col   = p / 4;
        row   = p % 4;
        digit = int'((s >> (4 * (3 - col))) & 16'hF);
        r     = (col % 2 == 1) ? 3 - row : row;
        return (((digit >> r) & 1) != 0) ? ON_C : OFF_C;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the IDLE cycle; returns in the LOAD cycle.
    task automatic start_frame(input logic [15:0] d);
        digits    = d;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        check_eq("load_busy", 32'(busy), 1);
        check_eq("load_valid", 32'(pix_valid), 0);
    endtask

    // Runs from the LOAD cycle until the cycle after frame_done (or abort).
    // rmode: 0 ready always, 1 ready 1-of-4, 2 random.
    task automatic run_frame(input logic [15:0] snap, input int rmode, input int idle_delay,
                             input int chg_at, input logic [15:0] chg_val, input bit req_mid,
                             input bit req_done, input int abort_at);
        int          n = 0;
        int          idle_cnt = 0;
        int          gap = 0;
        bit          done = 1'b0;
        bit          aborted = 1'b0;
        bit          held = 1'b0;
        logic [23:0] held_word = '0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (abort_at >= 0 && n == abort_at) begin
                aborted = 1'b1;
                break;
            end
            frame_req = 1'b0;
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (k % 4 == 1);
                default: pix_ready = ($urandom & 1) != 0;
            endcase
            tx_idle = 1'b0;
            if (n == 16) begin
                if (idle_cnt >= idle_delay) tx_idle = 1'b1;
                idle_cnt++;
            end
            if (n >= chg_at) digits = chg_val;
            if (req_mid && (k == 6 || k == 12)) frame_req = 1'b1;
            if (req_done && frame_done) frame_req = 1'b1;

            check_eq("busy_in_frame", 32'(busy), 1);
            if (held) begin
                check_eq("stall_valid", 32'(pix_valid), 1);
                check_eq("stall_data", 32'(pix_data), 32'(held_word));
            end
            if (n == 16 && tx_idle) gap++;
            if (frame_done) begin
                check_eq("words_before_done", n, 16);
                check_eq("latch_gap", gap, LATCH + 1);
                done = 1'b1;
            end
            if (n == 16) check_eq("valid_after_last", 32'(pix_valid), 0);
            if (pix_valid && pix_ready && n < 16) begin
                check_eq($sformatf("pix%0d", n), 32'(pix_data), 32'(exp_word(snap, n)));
                n++;
            end
            held      = pix_valid && !pix_ready;
            held_word = pix_data;
            step();
        end
        frame_req = 1'b0;
        tx_idle   = 1'b1;
        if (!aborted) check_eq("frame_timeout", 32'(done), 1);
    endtask

    // After a frame with nothing pending the block must stay idle.
    task automatic post_idle();
        check_eq("post_busy", 32'(busy), 0);
        check_eq("post_done_pulse", 32'(frame_done), 0);
        repeat (3) step();
        check_eq("idle_stays", 32'(busy), 0);
    endtask

    initial begin
        logic [15:0] d;
        #1;
        check_eq("rst_valid", 32'(pix_valid), 0);
        check_eq("rst_data", 32'(pix_data), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        check_eq("idle_busy", 32'(busy), 0);

        // Directed pattern, free-flowing ready.
        start_frame(16'h1234);
        run_frame(16'h1234, 0, 0, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Backpressure 1 high / 3 low, all ON.
        start_frame(16'hFFFF);
        run_frame(16'hFFFF, 1, 3, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Digits change mid-frame; current frame keeps the snapshot.
        start_frame(16'h0000);
        run_frame(16'h0000, 2, 5, 5, 16'h9999, 1'b0, 1'b0, -1);
        post_idle();
        start_frame(digits);
        run_frame(16'h9999, 0, 2, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Requests during SEND and at the frame_done exit merge into one frame.
        start_frame(16'h0559);
        run_frame(16'h0559, 0, 1, 99, 16'h0, 1'b1, 1'b1, -1);
        check_eq("gap_busy_low", 32'(busy), 0);
        digits = 16'h2147;
        step();
        check_eq("pending_starts", 32'(busy), 1);
        run_frame(16'h2147, 2, 0, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Serializer slow to go idle.
        start_frame(16'h0808);
        run_frame(16'h0808, 0, 100, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Reset at pixel 9 with a request pending.
        start_frame(16'h3141);
        run_frame(16'h3141, 0, 0, 99, 16'h0, 1'b1, 1'b0, 9);
        check_eq("pre_reset_valid", 32'(pix_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(pix_valid), 0);
        check_eq("rst_mid_busy", 32'(busy), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        step();
        repeat (3) step();
        check_eq("rst_no_pending", 32'(busy), 0);
        start_frame(16'h5926);
        run_frame(16'h5926, 0, 0, 99, 16'h0, 1'b0, 1'b0, -1);
        post_idle();

        // Randomized frames.
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            start_frame(d);
            run_frame(d, int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 16)), 16'($urandom), 1'b0, 1'b0, -1);
            post_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
